// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC and fetch sequencer driving the PC register load port.
// Define PC_ALIGN_CHECK_EN to fault on redirect targets that are not word aligned.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4,
   parameter logic [3:0]  TIMEOUT  = 4'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic [31:0] PCin,
   output logic        load,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        halt,
   output logic        halted,
   output logic        fault
);
   typedef enum logic [2:0] {INIT, FETCH, ISSUE, HALT, FAULT} state_t;
   state_t      state, state_n;
   logic        pend, pend_n;
   logic [31:0] saved, saved_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] tgt;
   logic        redir, bad;
   // a branch resolved this cycle overrides any target saved earlier in the fetch
   assign redir = br_taken | pend;
   assign tgt   = br_taken ? br_target : saved;
`ifdef PC_ALIGN_CHECK_EN
   assign bad = tgt[1:0] != 2'b00;
`else
   assign bad = 1'b0;
`endif
   assign imem_req    = !rst && state == FETCH;
   assign instr_valid = !rst && state == ISSUE;
   assign halted      = !rst && state == HALT;
   assign fault       = !rst && state == FAULT;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         pend  <= 1'b0;
         saved <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         pend  <= pend_n;
         saved <= saved_n;
         cnt   <= cnt_n;
      end
   end
   always_comb begin
      state_n = state;
      pend_n  = pend;
      saved_n = saved;
      cnt_n   = cnt;
      load    = 1'b0;
      PCin    = '0;
      if (!rst) begin
         case (state)
            INIT: begin
               load    = 1'b1;
               PCin    = RESET_PC;
               state_n = FETCH;
            end
            FETCH: begin
               if (imem_ready) begin
                  cnt_n  = '0;
                  pend_n = 1'b0;
                  if (redir && bad) state_n = FAULT;
                  else if (redir) begin
                     load = 1'b1;
                     PCin = tgt;
                  end else state_n = ISSUE;
               end else begin
                  if (br_taken) begin
                     pend_n  = 1'b1;
                     saved_n = br_target;
                  end
                  if (cnt == TIMEOUT - 4'd1) state_n = FAULT;
                  else cnt_n = cnt + 4'd1;
               end
            end
            ISSUE: begin
               if (br_taken) begin
                  if (bad) state_n = FAULT;
                  else begin
                     load    = 1'b1;
                     PCin    = br_target;
                     state_n = FETCH;
                  end
               end else if (!stall) begin
                  if (halt) state_n = HALT;
                  else begin
                     load    = 1'b1;
                     PCin    = pc_cur + PC_INC;
                     state_n = FETCH;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized episodes against a transaction-level model, scoreboard checked.
module tb_pc_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_cur = '0, br_target = '0, PCin;
  logic        imem_ready = 1'b0, stall = 1'b0, br_taken = 1'b0, halt = 1'b0;
  logic        load, imem_req, instr_valid, halted, fault;
  typedef struct packed {
    logic        load;
    logic [31:0] pcin;
    logic        req;
    logic        iv;
    logic        hl;
    logic        ft;
  } obs_t;
  obs_t exp_q[$];
  int   checks = 0, passed = 0, cyc = 0;
  always #5 clk = ~clk;
  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .PCin(PCin), .load(load),
    .imem_req(imem_req), .imem_ready(imem_ready), .instr_valid(instr_valid),
    .stall(stall), .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .halted(halted), .fault(fault)
  );
  always @(posedge clk) if (load) pc_cur <= PCin;
  typedef enum {M_INIT, M_FETCH, M_ISSUE, M_HALT, M_FAULT} mode_t;
  mode_t       mode = M_INIT;
  logic [31:0] m_pc = '0, m_saved = '0;
  bit          m_pend = 0;
  int          waited = 0;
  function automatic bit misaligned(logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction
  task automatic go_to(input logic [31:0] t, inout obs_t e, input mode_t after);
    if (misaligned(t)) mode = M_FAULT;
    else begin
      e.load = 1'b1;
      e.pcin = t;
      m_pc   = t;
      mode   = after;
    end
  endtask
  task automatic step();
    obs_t e;
    e = '0;
    if (rst) begin
      mode = M_INIT;
      m_pend = 0;
      waited = 0;
    end else if (mode == M_INIT) go_to(32'h0, e, M_FETCH);
    else if (mode == M_FETCH) begin
      e.req = 1'b1;
      if (!imem_ready) begin
        if (br_taken) begin
          m_pend  = 1;
          m_saved = br_target;
        end
        waited++;
        if (waited == 15) mode = M_FAULT;
      end else begin
        waited = 0;
        if (br_taken || m_pend) go_to(br_taken ? br_target : m_saved, e, M_FETCH);
        else mode = M_ISSUE;
        m_pend = 0;
      end
    end else if (mode == M_ISSUE) begin
      e.iv = 1'b1;
      if (br_taken) go_to(br_target, e, M_FETCH);
      else if (!stall && halt) mode = M_HALT;
      else if (!stall) go_to(m_pc + 32'd4, e, M_FETCH);
    end else if (mode == M_HALT) e.hl = 1'b1;
    else e.ft = 1'b1;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {load, PCin, imem_req, instr_valid, halted, fault};
      checks++;
      if (a == e) passed++;
      else $display("FAIL outputs cycle %0d: got load=%b PCin=%h req=%b iv=%b halted=%b fault=%b, want load=%b PCin=%h req=%b iv=%b halted=%b fault=%b",
                    cyc, a.load, a.pcin, a.req, a.iv, a.hl, a.ft, e.load, e.pcin, e.req, e.iv, e.hl, e.ft);
    end
  end
  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h0000_0100;
      1: return 32'h0000_0200;
      2: return 32'hFFFF_FFFC;
      3: return 32'h0000_0102;
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction
  initial begin
    int p_rdy, p_br, p_st;
    for (int ep = 0; ep < 40; ep++) begin
      p_rdy = (ep % 4 == 0) ? 0 : (ep % 4 == 1) ? 100 : 50;
      p_br  = $urandom_range(0, 25);
      p_st  = $urandom_range(0, 50);
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        #1;
        rst        = (c == 0) || ($urandom_range(0, 199) == 0);
        imem_ready = $urandom_range(0, 99) < p_rdy;
        br_taken   = $urandom_range(0, 99) < p_br;
        br_target  = pick_target();
        stall      = $urandom_range(0, 99) < p_st;
        halt       = $urandom_range(0, 99) < 8;
        step();
      end
    end
    @(posedge clk);
    #1;
    rst        = 1'b1;
    imem_ready = 1'b0;
    br_taken   = 1'b0;
    stall      = 1'b0;
    halt       = 1'b0;
    step();
    #1;
    checks++;
    if ({load, PCin, imem_req, instr_valid, halted, fault} == '0) passed++;
    else $display("FAIL reset state: load=%b PCin=%h req=%b iv=%b halted=%b fault=%b",
                  load, PCin, imem_req, instr_valid, halted, fault);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
    end
    @(posedge clk);
    #1;
    step();
    #1;
    checks++;
    if (fault && !imem_req && !load) passed++;
    else $display("FAIL expired wait: fault=%b req=%b load=%b", fault, imem_req, load);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC and fetch sequencer that sits directly upstream of the program counter register.
- Drives the register's PCin/load pair and reads its current value back on pc_cur.
- Runs the instruction-memory request handshake, holds fetched instructions for decode under stall, applies taken-branch redirects, and handles halt and fetch-timeout faults.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on the first cycle after reset.
- PC_INC, 4: sequential increment added to pc_cur.
- TIMEOUT, 15: maximum FETCH wait cycles before a fault; 4-bit counter width, range 1..15.

Ports:
- clk  in  1: system clock; all state updates on the rising edge.
- rst  in  1: synchronous reset, active-high.
- pc_cur  in  32: current PC from the program counter register.
- PCin  out  32: next PC value to the program counter register.
- load  out  1: PC register load enable.
- imem_req  out  1: instruction fetch request at address pc_cur.
- imem_ready  in  1: memory returns instruction data this cycle.
- instr_valid  out  1: fetched instruction held for decode.
- stall  in  1: decode cannot accept the instruction this cycle.
- br_taken  in  1: taken branch/jump resolved this cycle.
- br_target  in  32: redirect target, valid when br_taken=1.
- halt  in  1: decode flags the accepted instruction as halt.
- halted  out  1: sticky, sequencer stopped.
- fault  out  1: sticky, fetch timeout (or misaligned target, see Optional Feature).

Behaviour:
- Reset: synchronous active-high, sampled at the clk edge.
  - While rst=1: load=0, PCin=0, imem_req=0, instr_valid=0, halted=0, fault=0.
  - State goes to INIT; redirect-pending flag, saved target and timeout counter are cleared.
  - rst mid-fetch abandons the request; imem_ready arriving that cycle is ignored.
- Output timing: load and PCin are combinational from state and inputs, so the PC register updates on the same edge as the sequencer's transition. All other outputs are registered or pure state decodes.
- INIT:
  - load=1, PCin=RESET_PC.
  - Next state FETCH.
- FETCH:
  - imem_req=1; timeout counter increments each cycle imem_ready=0.
  - If br_taken=1 and imem_ready=0: save br_target and set the pending flag. A newer br_taken overwrites the saved target.
  - If imem_ready=1 with br_taken=1 or pending set: the instruction is dropped.
    - load=1; PCin = br_target if br_taken=1, else the saved target (the current-cycle target wins).
    - Pending is cleared; stay in FETCH; counter reset.
  - If imem_ready=1 with no redirect: go to ISSUE; counter reset.
  - Counter reaching TIMEOUT with imem_ready=0: go to FAULT.
- ISSUE:
  - instr_valid=1; imem_req=0.
  - br_taken=1 (any stall value): instruction dropped; load=1, PCin=br_target; go to FETCH.
  - Else stall=1: hold, load=0.
  - Else halt=1: go to HALT, load=0.
  - Else: load=1, PCin=pc_cur+PC_INC (mod 2^32; 32'hFFFF_FFFC+4 wraps to 0); go to FETCH.
- HALT: halted=1; load=0; imem_req=0; br_taken ignored; exit only via rst.
- FAULT: fault=1; load=0; imem_req=0; exit only via rst.
- Priority in every state: rst > br_taken > stall > halt.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: a redirect target with [1:0]!=0 (from br_taken or the saved target) is not loaded. load=0, state goes to FAULT, fault=1 from the next cycle.
- Not defined: targets are loaded unmodified with no alignment check; fault is raised only by timeout.

Test Plan:
- Reset then idle memory: rst 1 cycle, imem_ready=1 every FETCH, stall=0 -> load pulses with PCin 0x0, 0x4, 0x8, 0xC; instr_valid high one cycle per fetch.
- Stall hold: stall=1 for 3 cycles in ISSUE at pc_cur=0x10 -> instr_valid held 3+1 cycles, load=0 during stall, then PCin=0x14.
- Redirect during pending fetch: FETCH at 0x20, br_taken with target 0x100 while imem_ready=0, ready 2 cycles later -> instruction dropped, load=1 with PCin=0x100, no instr_valid for 0x20.
- Simultaneous redirect and ready: imem_ready=1 and br_taken with target 0x200 in the same cycle -> PCin=0x200, instr_valid stays 0.
- Timeout: imem_ready held 0 for 15 FETCH cycles -> fault=1 next cycle, imem_req=0, load=0 until rst.
- Halt and alignment: halt=1 with stall=0 in ISSUE -> halted=1, no further load. With PC_ALIGN_CHECK_EN defined, target 0x102 -> fault=1 and PC not loaded.
